sdram_arbiter: RTL and testbench

Two-master request arbiter that sits directly upstream of the SDRAM controller core and drives its command port. It accepts read and byte-masked write requests from two independent masters (port 0, port 1) and buffers one winning request in a holding register. It issues that request to the core when the core signals ready, and routes the returned read data back to the requesting master.

---
 rtl/sdram_arbiter_if.sv | 51 +++++
 rtl/sdram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Bundle of the two master request ports and the SDRAM core command port.
// slave modport is the arbiter's view; master modport is the masters' and core's view.
// Widths follow ADDR_WIDTH and DATA_WIDTH, with BYTES = DATA_WIDTH/8 byte enables.
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  m0_rd;
    logic [BYTES-1:0]      m0_wr;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_ack;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_rd;
    logic [BYTES-1:0]      m1_wr;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_ack;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  core_rd;
    logic [BYTES-1:0]      core_wr;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_rdy;
    logic                  core_valid;
    logic [DATA_WIDTH-1:0] core_rdata;

    modport slave (
        input  m0_rd, m0_wr, m0_addr, m0_wdata,
        output m0_ack, m0_rvalid, m0_rdata,
        input  m1_rd, m1_wr, m1_addr, m1_wdata,
        output m1_ack, m1_rvalid, m1_rdata,
        output core_rd, core_wr, core_addr, core_wdata,
        input  core_rdy, core_valid, core_rdata
    );

    modport master (
        output m0_rd, m0_wr, m0_addr, m0_wdata,
        input  m0_ack, m0_rvalid, m0_rdata,
        output m1_rd, m1_wr, m1_addr, m1_wdata,
        input  m1_ack, m1_rvalid, m1_rdata,
        input  core_rd, core_wr, core_addr, core_wdata,
        output core_rdy, core_valid, core_rdata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-master arbiter feeding the SDRAM core command port through a single holding register.
// Latency: ack is combinational in IDLE; the command reaches the core the next cycle; rvalid comes 1 cycle after core_valid.
// Backpressure: while core_rdy is low the held command stays on the core port and no new grant is made.
// Macro SDRAM_ARB_RR_EN selects round-robin tie-breaking; without it port 0 always wins a tie.
// DATA_WIDTH must be 8, 16 or 32.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    sdram_arbiter_if.slave    bus
);
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t                state;
    logic                  hold_rd;
    logic [BYTES-1:0]      hold_wr;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;
    logic                  hold_id;
    logic                  m0_rvalid_q;
    logic                  m1_rvalid_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;

    logic                  req0;
    logic                  req1;
    logic                  win;
    logic                  grant;
    logic                  sel_rd;
    logic [BYTES-1:0]      sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef SDRAM_ARB_RR_EN
    logic                  last;
`endif

    // Request detection: any byte enable counts as a write.
    always_comb begin
        req0 = bus.m0_rd | (|bus.m0_wr);
        req1 = bus.m1_rd | (|bus.m1_wr);
    end

    // Winner select (0 = port 0, 1 = port 1).
    always_comb begin
`ifdef SDRAM_ARB_RR_EN
        win = (req0 & req1) ? ~last : ~req0;
`else
        win = ~req0;
`endif
    end

    // Grant only from IDLE, never while reset is held; steer the winner's request.
    always_comb begin
        grant     = ~rst & (state == IDLE) & (req0 | req1);
        sel_rd    = win ? bus.m1_rd    : bus.m0_rd;
        sel_wr    = win ? bus.m1_wr    : bus.m0_wr;
        sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    end

    // The hold registers drive the core directly; they are non-zero only while in ISSUE.
    assign bus.m0_ack     = grant & ~win;
    assign bus.m1_ack     = grant & win;
    assign bus.core_rd    = hold_rd;
    assign bus.core_wr    = hold_wr;
    assign bus.core_addr  = hold_addr;
    assign bus.core_wdata = hold_wdata;
    assign bus.m0_rvalid  = m0_rvalid_q;
    assign bus.m1_rvalid  = m1_rvalid_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m1_rdata   = m1_rdata_q;

    // Control FSM: capture in IDLE, present in ISSUE, wait for read data in WAIT_RD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_rd     <= 1'b0;
            hold_wr     <= '0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            hold_id     <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
`ifdef SDRAM_ARB_RR_EN
            last        <= 1'b1;
`endif
        end else begin
            // Read-return outputs are single-cycle pulses; data is zero otherwise.
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        hold_rd    <= sel_rd;
                        // A request with both rd and byte enables is a read.
                        hold_wr    <= sel_rd ? '0 : sel_wr;
                        hold_addr  <= sel_addr;
                        hold_wdata <= sel_wdata;
                        hold_id    <= win;
`ifdef SDRAM_ARB_RR_EN
                        last       <= win;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.core_rdy) begin
                        // Clearing here keeps the core from seeing the command twice.
                        hold_rd    <= 1'b0;
                        hold_wr    <= '0;
                        hold_addr  <= '0;
                        hold_wdata <= '0;
                        state      <= hold_rd ? WAIT_RD : IDLE;
                    end
                end
                WAIT_RD: begin
                    if (bus.core_valid) begin
                        if (hold_id) begin
                            m1_rvalid_q <= 1'b1;
                            m1_rdata_q  <= bus.core_rdata;
                        end else begin
                            m0_rvalid_q <= 1'b1;
                            m0_rdata_q  <= bus.core_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a per-cycle vector table plus hand sequences
// for core backpressure, simultaneous requests, and reset during an outstanding read.
module tb_sdram_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sdram_arbiter_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) bus ();

    sdram_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic         rst;
        logic         m0_rd;
        logic [1:0]   m0_wr;
        logic [23:0]  m0_addr;
        logic [15:0]  m0_wdata;
        logic         m1_rd;
        logic [1:0]   m1_wr;
        logic [23:0]  m1_addr;
        logic [15:0]  m1_wdata;
        logic         core_rdy;
        logic         core_valid;
        logic [15:0]  core_rdata;
        logic [78:0]  exp;
    } vec_t;

    vec_t tbl [15];

    // Expected output word: {m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    // core_rd, core_wr, core_addr, core_wdata}
    function automatic logic [78:0] pk(input logic a0, input logic a1, input logic v0, input logic v1,
                                       input logic [15:0] d0, input logic [15:0] d1, input logic crd,
                                       input logic [1:0] cwr, input logic [23:0] ca, input logic [15:0] cwd);
        return {a0, a1, v0, v1, d0, d1, crd, cwr, ca, cwd};
    endfunction

    function automatic logic [78:0] outs();
        return {bus.m0_ack, bus.m1_ack, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata,
                bus.core_rd, bus.core_wr, bus.core_addr, bus.core_wdata};
    endfunction

    task automatic check(input string nm, input logic [78:0] act, input logic [78:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.m0_rd = 1'b0; bus.m0_wr = 2'b00; bus.m0_addr = 24'h0; bus.m0_wdata = 16'h0;
        bus.m1_rd = 1'b0; bus.m1_wr = 2'b00; bus.m1_addr = 24'h0; bus.m1_wdata = 16'h0;
        bus.core_rdy = 1'b1; bus.core_valid = 1'b0; bus.core_rdata = 16'h0;
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus.m0_rd = v.m0_rd; bus.m0_wr = v.m0_wr; bus.m0_addr = v.m0_addr; bus.m0_wdata = v.m0_wdata;
        bus.m1_rd = v.m1_rd; bus.m1_wr = v.m1_wr; bus.m1_addr = v.m1_addr; bus.m1_wdata = v.m1_wdata;
        bus.core_rdy = v.core_rdy; bus.core_valid = v.core_valid; bus.core_rdata = v.core_rdata;
    endtask

    initial begin
        logic [78:0] z;
        logic [78:0] busy_exp;
        bit          rr;
        int          w;

        checks = 0;
        errors = 0;
        z = '0;
`ifdef SDRAM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst = 1'b1;
        clear_inputs();

        //         name                  rst  m0rd m0wr   m0addr       m0wdata    m1rd m1wr   m1addr       m1wdata  rdy  cval crdata     expected
        tbl[0]  = '{"reset_idle",        1'b1, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};
        tbl[1]  = '{"reset_gates_ack",   1'b1, 1'b0, 2'b11, 24'h000100, 16'hBEEF, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};
        tbl[2]  = '{"wr_ack",            1'b0, 1'b0, 2'b11, 24'h000100, 16'hBEEF, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    pk(1, 0, 0, 0, 16'h0, 16'h0, 0, 2'b00, 24'h0, 16'h0)};
        tbl[3]  = '{"wr_issue",          1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    pk(0, 0, 0, 0, 16'h0, 16'h0, 0, 2'b11, 24'h000100, 16'hBEEF)};
        tbl[4]  = '{"rd_ack",            1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 2'b00, 24'h0ABCDE, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    pk(0, 1, 0, 0, 16'h0, 16'h0, 0, 2'b00, 24'h0, 16'h0)};
        tbl[5]  = '{"rd_issue",          1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    pk(0, 0, 0, 0, 16'h0, 16'h0, 1, 2'b00, 24'h0ABCDE, 16'h0)};
        tbl[6]  = '{"rd_wait_block1",    1'b0, 1'b0, 2'b01, 24'h000055, 16'h00AA, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};
        tbl[7]  = '{"rd_wait_block2",    1'b0, 1'b0, 2'b01, 24'h000055, 16'h00AA, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};
        tbl[8]  = '{"rd_wait_block3",    1'b0, 1'b0, 2'b01, 24'h000055, 16'h00AA, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};
        tbl[9]  = '{"rd_wait_block4",    1'b0, 1'b0, 2'b01, 24'h000055, 16'h00AA, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};
        tbl[10] = '{"rd_core_valid",     1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b1, 16'h1234, z};
        tbl[11] = '{"rd_rvalid",         1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    pk(0, 0, 0, 1, 16'h0, 16'h1234, 0, 2'b00, 24'h0, 16'h0)};
        tbl[12] = '{"rvalid_pulse_end",  1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};
        tbl[13] = '{"spurious_valid",    1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, z};
        tbl[14] = '{"spurious_no_rvalid",1'b0, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b0, 2'b00, 24'h000000, 16'h0000, 1'b1, 1'b0, 16'h0000, z};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check(tbl[i].nm, outs(), tbl[i].exp);
        end

        // Core busy: m1 write held on the core port for 10 stalled cycles while m0 waits.
        @(negedge clk);
        clear_inputs();
        bus.core_rdy = 1'b0;
        bus.m1_wr = 2'b10; bus.m1_addr = 24'h123456; bus.m1_wdata = 16'h5A5A;
        #1;
        check("busy_ack", outs(), pk(0, 1, 0, 0, 16'h0, 16'h0, 0, 2'b00, 24'h0, 16'h0));
        busy_exp = pk(0, 0, 0, 0, 16'h0, 16'h0, 0, 2'b10, 24'h123456, 16'h5A5A);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.m1_wr = 2'b00; bus.m1_addr = 24'h0; bus.m1_wdata = 16'h0;
            bus.m0_rd = 1'b1; bus.m0_addr = 24'h000200;
            #1;
            check("busy_hold", outs(), busy_exp);
        end
        @(negedge clk);
        bus.core_rdy = 1'b1;
        #1;
        check("busy_take_cycle", outs(), busy_exp);
        @(negedge clk);
        #1;
        check("busy_next_grant", outs(), pk(1, 0, 0, 0, 16'h0, 16'h0, 0, 2'b00, 24'h0, 16'h0));
        @(negedge clk);
        bus.m0_rd = 1'b0; bus.m0_addr = 24'h0;
        #1;
        check("m0_rd_issue", outs(), pk(0, 0, 0, 0, 16'h0, 16'h0, 1, 2'b00, 24'h000200, 16'h0));
        @(negedge clk);
        bus.core_valid = 1'b1; bus.core_rdata = 16'hC0DE;
        #1;
        check("m0_rd_wait", outs(), z);
        @(negedge clk);
        bus.core_valid = 1'b0; bus.core_rdata = 16'h0;
        #1;
        check("m0_rvalid", outs(), pk(0, 0, 1, 0, 16'hC0DE, 16'h0, 0, 2'b00, 24'h0, 16'h0));

        // Simultaneous requests from both masters after a fresh reset, 4 back-to-back rounds.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.m0_wr = 2'b01; bus.m0_addr = 24'h000010; bus.m0_wdata = 16'h1111;
        bus.m1_wr = 2'b10; bus.m1_addr = 24'h000020; bus.m1_wdata = 16'h2222;
        #1;
        for (int r = 0; r < 4; r++) begin
            w = rr ? (r % 2) : 0;
            check("tie_ack", {77'd0, bus.m0_ack, bus.m1_ack}, (w == 1) ? 79'd1 : 79'd2);
            @(negedge clk);
            #1;
            check("tie_issue", {77'd0, bus.core_wr}, (w == 1) ? 79'd2 : 79'd1);
            @(negedge clk);
            #1;
        end
        clear_inputs();

        // Reset during WAIT_RD abandons the read; a late core_valid must not produce rvalid.
        @(negedge clk);
        bus.m1_rd = 1'b1; bus.m1_addr = 24'h000300;
        #1;
        check("rst_rd_ack", outs(), pk(0, 1, 0, 0, 16'h0, 16'h0, 0, 2'b00, 24'h0, 16'h0));
        @(negedge clk);
        bus.m1_rd = 1'b0; bus.m1_addr = 24'h0;
        #1;
        check("rst_rd_issue", outs(), pk(0, 0, 0, 0, 16'h0, 16'h0, 1, 2'b00, 24'h000300, 16'h0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_wait", outs(), z);
        @(negedge clk);
        rst = 1'b0;
        bus.core_valid = 1'b1; bus.core_rdata = 16'hDEAD;
        #1;
        check("rst_outputs_zero", outs(), z);
        @(negedge clk);
        bus.core_valid = 1'b0; bus.core_rdata = 16'h0;
        #1;
        check("rst_no_rvalid", outs(), z);
        @(negedge clk);
        bus.m0_wr = 2'b11; bus.m0_addr = 24'h000400; bus.m0_wdata = 16'h7777;
        #1;
        check("post_rst_wr_ack", outs(), pk(1, 0, 0, 0, 16'h0, 16'h0, 0, 2'b00, 24'h0, 16'h0));
        @(negedge clk);
        clear_inputs();
        #1;
        check("post_rst_wr_issue", outs(), pk(0, 0, 0, 0, 16'h0, 16'h0, 0, 2'b11, 24'h000400, 16'h7777));
        @(negedge clk);
        #1;
        check("post_rst_idle", outs(), z);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
